// File: rtl/gray_codec_pkg.sv
// Shared constants and helpers for the Gray code converter.
package gray_codec_pkg;

    localparam int GRAY_W_DEFAULT = 8;

    localparam logic MODE_B2G = 1'b0;  // binary in, Gray out
    localparam logic MODE_G2B = 1'b1;  // Gray in, binary out

    // Number of set bits in a word of up to 32 bits (narrower words are zero-extended).
    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] n;
        n = 6'd0;
        for (int i = 0; i < 32; i++) begin
            n = n + 6'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/gray_codec_if.sv
// Stream bundle for gray_codec: one input channel and one output channel.
// Handshake: a beat moves on a rising clk edge when valid && ready on that
// channel; the sender holds valid and payload stable until that happens, and
// ready may depend combinationally on the receiver's state.
interface gray_codec_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_mode;
    logic         out_err;

    // Converter side.
    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_mode, out_err
    );

    // Producer/consumer side.
    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_mode, out_err
    );
endinterface

// File: rtl/gray_xfm.sv
// Combinational binary<->Gray transform, direction selected per word.
module gray_xfm
    import gray_codec_pkg::*;
#(
    parameter int W = GRAY_W_DEFAULT
) (
    input  logic [W-1:0] din,
    input  logic         mode,
    output logic [W-1:0] dout
);

    logic [W-1:0] b2g;
    logic [W-1:0] g2b;

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        b2g = din ^ (din >> 1);
        g2b = '0;
        for (int i = 0; i < W; i++) begin
            g2b[i] = ^(din >> i);
        end
        dout = (mode == MODE_G2B) ? g2b : b2g;
    end

endmodule

// File: rtl/gray_codec.sv
// Two-stage pipelined Gray/binary converter with valid/ready flow control.
// S1 registers the raw word and mode; S2 registers the converted word.
// Optional Gray adjacency checker: define GRAY_CODEC_ADJ_CHK_EN.
module gray_codec
    import gray_codec_pkg::*;
#(
    parameter int W = GRAY_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    gray_codec_if.slave  bus,
    input  logic         clr_err,
    output logic         err_sticky
);

    logic         rdy_en;
    logic         s1_valid, s1_mode, s1_err;
    logic [W-1:0] s1_data;
    logic         s2_valid, s2_mode, s2_err;
    logic [W-1:0] s2_data;
    logic [W-1:0] xfm_out;
    logic         s1_adv, s2_adv, in_fire, out_fire;
    logic         beat_err;

    assign s2_adv   = !s2_valid || bus.out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    // rdy_en keeps in_ready low during reset and lifts it at the first edge after release.
    assign bus.in_ready = rdy_en && s1_adv;
    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = s2_valid && bus.out_ready;

    assign bus.out_valid = s2_valid;
    assign bus.out_data  = s2_data;
    assign bus.out_mode  = s2_mode;
    assign bus.out_err   = s2_err;

    gray_xfm #(.W(W)) u_xfm (
        .din  (s1_data),
        .mode (s1_mode),
        .dout (xfm_out)
    );

    // Input acceptance enable, held off while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_en <= 1'b0;
        else        rdy_en <= 1'b1;
    end

    // Stage 1: capture raw word, mode and adjacency flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_mode  <= 1'b0;
            s1_err   <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_fire;
            if (in_fire) begin
                s1_data <= bus.in_data;
                s1_mode <= bus.in_mode;
                s1_err  <= beat_err;
            end
        end
    end

    // Stage 2: capture the converted word with its mode and flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_mode  <= 1'b0;
            s2_err   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= xfm_out;
                s2_mode <= s1_mode;
                s2_err  <= s1_err;
            end
        end
    end

`ifdef GRAY_CODEC_ADJ_CHK_EN
    logic [W-1:0] hist_q;
    logic         hist_valid;
    logic [5:0]   diff_bits;

    assign diff_bits = popcount32(32'(bus.in_data ^ hist_q));
    assign beat_err  = (bus.in_mode == MODE_G2B) && hist_valid && (diff_bits != 6'd1);

    // History of the last accepted Gray-input word; clear takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q     <= '0;
            hist_valid <= 1'b0;
        end else if (clr_err) begin
            hist_valid <= 1'b0;
        end else if (in_fire && bus.in_mode == MODE_G2B) begin
            hist_q     <= bus.in_data;
            hist_valid <= 1'b1;
        end
    end

    // Sticky error: set when a flagged beat leaves, set beats a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 err_sticky <= 1'b0;
        else if (out_fire && s2_err) err_sticky <= 1'b1;
        else if (clr_err)           err_sticky <= 1'b0;
    end
`else
    logic clr_err_unused;
    logic out_fire_unused;

    assign clr_err_unused  = clr_err;
    assign out_fire_unused = out_fire;
    assign beat_err        = 1'b0;
    assign err_sticky      = 1'b0;
`endif

endmodule

// File: tb/tb_gray_codec.sv
// Bench for gray_codec: directed beats, expected results queued at input
// handshake and popped by a monitor at each output handshake.
module tb_gray_codec;
    import gray_codec_pkg::*;

    localparam int W = 8;
`ifdef GRAY_CODEC_ADJ_CHK_EN
    localparam logic ADJ = 1'b1;
`else
    localparam logic ADJ = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic clr_err = 1'b0;
    logic err_sticky;
    int   cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gray_codec_if #(.W(W)) bus ();

    gray_codec #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .clr_err    (clr_err),
        .err_sticky (err_sticky)
    );

    // ---------------- scoreboard ----------------
    logic [W+1:0] exp_q[$];   // {mode, err, data}
    logic [W+1:0] mon_e;
    int n_cmp = 0;
    int n_bad = 0;
    int n_out = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    // ---------------- driver ----------------
    task automatic send(input logic [W-1:0] d, input logic m,
                        input logic [W-1:0] exp_d, input logic exp_e,
                        output int acc_cyc);
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_mode  = m;
        @(negedge clk);
        while (!bus.in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        acc_cyc = cyc;
        if (!bus.in_ready) fail_now("send");
        else exp_q.push_back({m, exp_e & ADJ, exp_d});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            k++;
            @(negedge clk);
        end
        if (exp_q.size() != 0) fail_now("drain");
        @(posedge clk);
        #1;
    endtask

    // ---------------- main ----------------
    initial begin
        int c0, c1, k, out0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_mode   = 1'b0;
        bus.out_ready = 1'b1;

        fork
            forever begin
                @(negedge clk);
                if (rst_n && bus.out_valid && bus.out_ready) begin
                    n_out++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_out: got 0x%0h, expected no beat", bus.out_data);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("out_data", 32'(bus.out_data), 32'(mon_e[W-1:0]));
                        check("out_mode", 32'(bus.out_mode), 32'(mon_e[W+1]));
                        check("out_err",  32'(bus.out_err),  32'(mon_e[W]));
                    end
                end
            end
        join_none

        // Reset values while rst_n is low.
        #12;
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_in_ready",  32'(bus.in_ready),  0);
        check("rst_out_data",  32'(bus.out_data),  0);
        check("rst_out_mode",  32'(bus.out_mode),  0);
        check("rst_out_err",   32'(bus.out_err),   0);
        check("rst_sticky",    32'(err_sticky),    0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", 32'(bus.in_ready), 1);

        // Single beat, latency to out_valid.
        send(8'h0B, MODE_B2G, 8'h0E, 1'b0, c0);
        k = 0;
        while (!bus.out_valid && k < 10) begin
            k++;
            @(negedge clk);
        end
        check("latency", 32'(cyc - c0), 2);
        wait_drain();

        // Back-to-back beats, one per cycle.
        c0 = cyc;
        send(8'hFF, MODE_G2B, 8'hAA, 1'b0, c1);
        send(8'hFF, MODE_B2G, 8'h80, 1'b0, c1);
        check("b2b_cycles", 32'(cyc - c0), 2);
        wait_drain();

        // Backpressure: two beats buffer, in_ready drops, output holds.
        bus.out_ready = 1'b0;
        fork
            begin
                send(8'h01, MODE_B2G, 8'h01, 1'b0, c1);
                send(8'h02, MODE_B2G, 8'h03, 1'b0, c1);
                send(8'h03, MODE_B2G, 8'h02, 1'b0, c1);
                send(8'h04, MODE_B2G, 8'h06, 1'b0, c1);
            end
            begin
                repeat (3) @(negedge clk);
                for (int i = 0; i < 3; i++) begin
                    check("bp_in_ready",  32'(bus.in_ready),  0);
                    check("bp_out_valid", 32'(bus.out_valid), 1);
                    check("bp_hold_data", 32'(bus.out_data),  32'h01);
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        wait_drain();

        // Adjacency: clear leftover history first.
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        send(8'h00, MODE_G2B, 8'h00, 1'b0, c1);
        send(8'h01, MODE_G2B, 8'h01, 1'b0, c1);
        send(8'h03, MODE_G2B, 8'h02, 1'b0, c1);
        send(8'h00, MODE_G2B, 8'h00, 1'b1, c1);
        wait_drain();
        check("sticky_set", 32'(err_sticky), 32'(ADJ));
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        check("sticky_clr", 32'(err_sticky), 0);
        send(8'h05, MODE_G2B, 8'h06, 1'b0, c1);
        send(8'h07, MODE_B2G, 8'h04, 1'b0, c1);   // must not touch history
        send(8'h04, MODE_G2B, 8'h07, 1'b0, c1);   // one bit from 0x05
        wait_drain();
        check("sticky_still_clr", 32'(err_sticky), 0);

        // Reset with both stages full: everything discarded.
        bus.out_ready = 1'b0;
        send(8'h11, MODE_B2G, 8'h19, 1'b0, c1);
        send(8'h22, MODE_B2G, 8'h33, 1'b0, c1);
        #2;
        check("full_out_valid", 32'(bus.out_valid), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 0);
        check("midrst_in_ready",  32'(bus.in_ready),  0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        out0 = n_out;
        repeat (6) @(negedge clk);
        check("no_stale_beats", 32'(n_out - out0), 0);
        check("in_ready_after_midrst", 32'(bus.in_ready), 1);

        // Fresh beat still flows after the mid-run reset.
        send(8'hA5, MODE_B2G, 8'hF7, 1'b0, c1);
        wait_drain();
        check("queue_empty", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
